// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the request, ALU and result signals around the ALU issue controller.
// The slave modport is the controller's view; master is the environment driving it.
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             req_valid_i;
   logic             req_ready_o;
   logic [1:0]       ALUOp_i;
   logic [5:0]       funct_i;
   logic [WIDTH-1:0] rs_data_i;
   logic [WIDTH-1:0] rt_data_i;
   logic [WIDTH-1:0] imm_i;
   logic             ALUSrc_i;
   logic [4:0]       rd_addr_i;
   logic [WIDTH-1:0] alu_data1_o;
   logic [WIDTH-1:0] alu_data2_o;
   logic [2:0]       alu_ctrl_o;
   logic [WIDTH-1:0] alu_data_i;
   logic             alu_zero_i;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [WIDTH-1:0] res_data_o;
   logic             res_zero_o;
   logic             res_branch_o;
   logic [4:0]       res_rd_o;
   logic             res_illegal_o;
   logic [CNT_W-1:0] op_count_o;

   modport slave (
      input  req_valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i, imm_i, ALUSrc_i, rd_addr_i,
      input  alu_data_i, alu_zero_i, res_ready_i,
      output req_ready_o, alu_data1_o, alu_data2_o, alu_ctrl_o,
      output res_valid_o, res_data_o, res_zero_o, res_branch_o, res_rd_o, res_illegal_o,
      output op_count_o
   );

   modport master (
      output req_valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i, imm_i, ALUSrc_i, rd_addr_i,
      output alu_data_i, alu_zero_i, res_ready_i,
      input  req_ready_o, alu_data1_o, alu_data2_o, alu_ctrl_o,
      input  res_valid_o, res_data_o, res_zero_o, res_branch_o, res_rd_o, res_illegal_o,
      input  op_count_o
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller for the single-cycle ALU: latches a decoded request,
// holds the ALU inputs for EXEC_CYCLES, captures the result and hands it off.
//
// state | meaning
// IDLE  | no op in flight, ready for a request
// EXEC  | ALU inputs held, settle counter running down
// DONE  | result captured and valid, waiting for consumer
module alu_issue_ctrl #(
   parameter int WIDTH       = 32,
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 16
) (
   input logic           clk_i,
   input logic           rst_i,
   alu_issue_ctrl_if.slave bus
);
   localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] data1_q, data2_q, res_data_q;
   logic [2:0]       ctrl_q, ctrl_dec;
   logic             illegal_dec, illegal_q, branch_q;
   logic             res_zero_q, res_branch_q, res_illegal_q;
   logic [4:0]       rd_q, res_rd_q;
   logic [CNT_W-1:0] op_cnt;
   logic             req_ready, accept, capture, handoff;

   always_comb begin
      ctrl_dec    = 3'b010;
      illegal_dec = 1'b0;
      case (bus.ALUOp_i)
         2'b01:   ctrl_dec = 3'b110;
         2'b11:   ctrl_dec = 3'b001;
         2'b10: begin
            case (bus.funct_i)
               6'b100000: ctrl_dec = 3'b010;
               6'b100010: ctrl_dec = 3'b110;
               6'b100100: ctrl_dec = 3'b000;
               6'b100101: ctrl_dec = 3'b001;
               6'b101010: ctrl_dec = 3'b111;
               default:   illegal_dec = 1'b1;
            endcase
         end
         default: ctrl_dec = 3'b010;
      endcase
   end

   // DONE forwards consumer readiness so a new op can start on the hand-off edge
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      capture   = 1'b0;
      handoff   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i) state_nxt = EXEC;
         end
         EXEC: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            req_ready = bus.res_ready_i;
            if (bus.res_ready_i) begin
               handoff   = 1'b1;
               state_nxt = bus.req_valid_i ? EXEC : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = bus.req_valid_i & req_ready;

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt           <= '0;
         data1_q       <= '0;
         data2_q       <= '0;
         ctrl_q        <= '0;
         illegal_q     <= 1'b0;
         branch_q      <= 1'b0;
         rd_q          <= '0;
         res_data_q    <= '0;
         res_zero_q    <= 1'b0;
         res_branch_q  <= 1'b0;
         res_illegal_q <= 1'b0;
         res_rd_q      <= '0;
         op_cnt        <= '0;
      end else begin
         if (accept) begin
            data1_q   <= bus.rs_data_i;
            data2_q   <= bus.ALUSrc_i ? bus.imm_i : bus.rt_data_i;
            ctrl_q    <= ctrl_dec;
            illegal_q <= illegal_dec;
            branch_q  <= (bus.ALUOp_i == 2'b01);
            rd_q      <= bus.rd_addr_i;
            cnt       <= CW'(EXEC_CYCLES - 1);
         end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (capture) begin
            res_data_q    <= bus.alu_data_i;
            res_zero_q    <= bus.alu_zero_i;
            res_branch_q  <= branch_q & bus.alu_zero_i;
            res_illegal_q <= illegal_q;
            res_rd_q      <= rd_q;
         end
         if (handoff) op_cnt <= op_cnt + CNT_W'(1);
      end
   end

   assign bus.req_ready_o   = req_ready;
   assign bus.alu_data1_o   = data1_q;
   assign bus.alu_data2_o   = data2_q;
   assign bus.alu_ctrl_o    = ctrl_q;
   assign bus.res_valid_o   = (state == DONE);
   assign bus.res_data_o    = res_data_q;
   assign bus.res_zero_o    = res_zero_q;
   assign bus.res_branch_o  = res_branch_q;
   assign bus.res_rd_o      = res_rd_q;
   assign bus.res_illegal_o = res_illegal_q;
   assign bus.op_count_o    = op_cnt;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with a behavioural ALU (EXEC_CYCLES=1)
// and one with a hand-driven ALU result (EXEC_CYCLES=3).
module tb_alu_issue_ctrl;
   logic clk_i = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_cnt_a = 0;

   always #5 clk_i = ~clk_i;

   alu_issue_ctrl_if #(.WIDTH(32), .CNT_W(16)) bus_a ();
   alu_issue_ctrl_if #(.WIDTH(32), .CNT_W(16)) bus_b ();

   alu_issue_ctrl #(.WIDTH(32), .EXEC_CYCLES(1), .CNT_W(16)) dut_a (
      .clk_i (clk_i),
      .rst_i (rst_a),
      .bus   (bus_a.slave)
   );

   alu_issue_ctrl #(.WIDTH(32), .EXEC_CYCLES(3), .CNT_W(16)) dut_b (
      .clk_i (clk_i),
      .rst_i (rst_b),
      .bus   (bus_b.slave)
   );

   // reference ALU for instance A
   logic [31:0] alu_r;
   always_comb begin
      alu_r = '0;
      case (bus_a.alu_ctrl_o)
         3'b010:  alu_r = bus_a.alu_data1_o + bus_a.alu_data2_o;
         3'b110:  alu_r = bus_a.alu_data1_o - bus_a.alu_data2_o;
         3'b000:  alu_r = bus_a.alu_data1_o & bus_a.alu_data2_o;
         3'b001:  alu_r = bus_a.alu_data1_o | bus_a.alu_data2_o;
         3'b111:  alu_r = ($signed(bus_a.alu_data1_o) < $signed(bus_a.alu_data2_o)) ? 32'd1 : 32'd0;
         default: alu_r = '0;
      endcase
   end
   assign bus_a.alu_data_i = alu_r;
   assign bus_a.alu_zero_i = (alu_r == 32'd0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_a(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] imm, input logic src,
                          input logic [4:0] rd);
      bus_a.req_valid_i = 1'b1;
      bus_a.ALUOp_i     = op;
      bus_a.funct_i     = fn;
      bus_a.rs_data_i   = rs;
      bus_a.rt_data_i   = rt;
      bus_a.imm_i       = imm;
      bus_a.ALUSrc_i    = src;
      bus_a.rd_addr_i   = rd;
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                         input logic src, input logic [4:0] rd, input logic [2:0] e_ctrl,
                         input logic [31:0] e_d2, input logic [31:0] e_res, input logic e_zero,
                         input logic e_br, input logic e_ill);
      @(negedge clk_i);
      drive_a(op, fn, rs, rt, imm, src, rd);
      chk({tag, ".req_ready"}, 32'(bus_a.req_ready_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      bus_a.req_valid_i = 1'b0;
      chk({tag, ".ctrl"}, 32'(bus_a.alu_ctrl_o), 32'(e_ctrl));
      chk({tag, ".data1"}, bus_a.alu_data1_o, rs);
      chk({tag, ".data2"}, bus_a.alu_data2_o, e_d2);
      chk({tag, ".busy"}, 32'(bus_a.req_ready_o), 32'd0);
      chk({tag, ".early_valid"}, 32'(bus_a.res_valid_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk({tag, ".valid"}, 32'(bus_a.res_valid_o), 32'd1);
      chk({tag, ".res"}, bus_a.res_data_o, e_res);
      chk({tag, ".zero"}, 32'(bus_a.res_zero_o), 32'(e_zero));
      chk({tag, ".branch"}, 32'(bus_a.res_branch_o), 32'(e_br));
      chk({tag, ".illegal"}, 32'(bus_a.res_illegal_o), 32'(e_ill));
      chk({tag, ".rd"}, 32'(bus_a.res_rd_o), 32'(rd));
      bus_a.res_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      bus_a.res_ready_i = 1'b0;
      exp_cnt_a++;
      chk({tag, ".count"}, 32'(bus_a.op_count_o), 32'(exp_cnt_a));
      chk({tag, ".after_valid"}, 32'(bus_a.res_valid_o), 32'd0);
      chk({tag, ".after_ready"}, 32'(bus_a.req_ready_o), 32'd1);
   endtask

   task automatic chk_reset(input string tag, input logic rv, input logic rr, input logic [15:0] cnt,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [2:0] ctl,
                            input logic [31:0] rdat);
      chk({tag, ".valid"}, 32'(rv), 32'd0);
      chk({tag, ".ready"}, 32'(rr), 32'd1);
      chk({tag, ".count"}, 32'(cnt), 32'd0);
      chk({tag, ".data1"}, d1, 32'd0);
      chk({tag, ".data2"}, d2, 32'd0);
      chk({tag, ".ctrl"}, 32'(ctl), 32'd0);
      chk({tag, ".res"}, rdat, 32'd0);
   endtask

   initial begin
      bus_a.req_valid_i = 1'b0; bus_a.ALUOp_i = '0; bus_a.funct_i = '0; bus_a.rs_data_i = '0;
      bus_a.rt_data_i = '0; bus_a.imm_i = '0; bus_a.ALUSrc_i = 1'b0; bus_a.rd_addr_i = '0;
      bus_a.res_ready_i = 1'b0;
      bus_b.req_valid_i = 1'b0; bus_b.ALUOp_i = '0; bus_b.funct_i = '0; bus_b.rs_data_i = '0;
      bus_b.rt_data_i = '0; bus_b.imm_i = '0; bus_b.ALUSrc_i = 1'b0; bus_b.rd_addr_i = '0;
      bus_b.res_ready_i = 1'b0; bus_b.alu_data_i = '0; bus_b.alu_zero_i = 1'b0;

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk_reset("rst_a", bus_a.res_valid_o, bus_a.req_ready_o, bus_a.op_count_o,
                bus_a.alu_data1_o, bus_a.alu_data2_o, bus_a.alu_ctrl_o, bus_a.res_data_o);
      chk_reset("rst_b", bus_b.res_valid_o, bus_b.req_ready_o, bus_b.op_count_o,
                bus_b.alu_data1_o, bus_b.alu_data2_o, bus_b.alu_ctrl_o, bus_b.res_data_o);
      rst_a = 1'b1;
      rst_b = 1'b1;

      //      tag        op     funct      rs        rt        imm    src rd  ctrl    d2        res       z  br il
      run_op("r_add",  2'b10, 6'b100000, 32'd5,    32'd7,    32'd0,  0, 3, 3'b010, 32'd7,    32'd12,   0, 0, 0);
      run_op("beq",    2'b01, 6'b000000, 32'h1234, 32'h1234, 32'd0,  0, 0, 3'b110, 32'h1234, 32'd0,    1, 1, 0);
      run_op("ori",    2'b11, 6'b000000, 32'hF0,   32'h55,   32'h0F, 1, 8, 3'b001, 32'h0F,   32'hFF,   0, 0, 0);
      run_op("slt",    2'b10, 6'b101010, 32'd3,    32'd9,    32'd0,  0, 5, 3'b111, 32'd9,    32'd1,    0, 0, 0);
      run_op("illegal",2'b10, 6'b000000, 32'd4,    32'd6,    32'd0,  0, 6, 3'b010, 32'd6,    32'd10,   0, 0, 1);
      run_op("r_and",  2'b10, 6'b100100, 32'hC,    32'hA,    32'd0,  0, 1, 3'b000, 32'hA,    32'h8,    0, 0, 0);
      run_op("r_sub",  2'b10, 6'b100010, 32'd9,    32'd4,    32'd0,  0, 2, 3'b110, 32'd4,    32'd5,    0, 0, 0);
      run_op("r_or",   2'b10, 6'b100101, 32'h30,   32'h03,   32'd0,  0, 9, 3'b001, 32'h03,   32'h33,   0, 0, 0);
      run_op("addi",   2'b00, 6'b111111, 32'd100,  32'd1,    32'hFFFFFFFF, 1, 4, 3'b010, 32'hFFFFFFFF, 32'd99, 0, 0, 0);
      run_op("sub_nz", 2'b01, 6'b000000, 32'd8,    32'd3,    32'd0,  0, 7, 3'b110, 32'd3,    32'd5,    0, 0, 0);

      // backpressure, then back-to-back accept on the hand-off edge
      @(negedge clk_i);
      drive_a(2'b00, 6'b0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd7);
      @(posedge clk_i);
      @(negedge clk_i);
      bus_a.req_valid_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("bp.valid", 32'(bus_a.res_valid_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         chk("bp.hold_res", bus_a.res_data_o, 32'd2);
         chk("bp.hold_rd", 32'(bus_a.res_rd_o), 32'd7);
         chk("bp.hold_valid", 32'(bus_a.res_valid_o), 32'd1);
         chk("bp.req_blocked", 32'(bus_a.req_ready_o), 32'd0);
      end
      bus_a.res_ready_i = 1'b1;
      drive_a(2'b01, 6'b0, 32'd10, 32'd3, 32'd0, 1'b0, 5'd9);
      #1;
      chk("b2b.req_ready", 32'(bus_a.req_ready_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      bus_a.res_ready_i = 1'b0;
      bus_a.req_valid_i = 1'b0;
      exp_cnt_a++;
      chk("b2b.count", 32'(bus_a.op_count_o), 32'(exp_cnt_a));
      chk("b2b.valid_low", 32'(bus_a.res_valid_o), 32'd0);
      chk("b2b.in_exec", 32'(bus_a.req_ready_o), 32'd0);
      chk("b2b.ctrl", 32'(bus_a.alu_ctrl_o), 32'd6);
      chk("b2b.data1", bus_a.alu_data1_o, 32'd10);
      chk("b2b.data2", bus_a.alu_data2_o, 32'd3);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("b2b.valid", 32'(bus_a.res_valid_o), 32'd1);
      chk("b2b.res", bus_a.res_data_o, 32'd7);
      chk("b2b.branch", 32'(bus_a.res_branch_o), 32'd0);
      chk("b2b.rd", 32'(bus_a.res_rd_o), 32'd9);
      bus_a.res_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      bus_a.res_ready_i = 1'b0;
      exp_cnt_a++;
      chk("b2b.count2", 32'(bus_a.op_count_o), 32'(exp_cnt_a));

      // EXEC_CYCLES=3: only the ALU value present at the third edge is captured
      bus_b.req_valid_i = 1'b1;
      bus_b.ALUOp_i     = 2'b00;
      bus_b.rs_data_i   = 32'd1;
      bus_b.rt_data_i   = 32'd2;
      bus_b.rd_addr_i   = 5'd4;
      bus_b.alu_data_i  = 32'hAAA;
      @(posedge clk_i);
      @(negedge clk_i);
      bus_b.req_valid_i = 1'b0;
      bus_b.alu_data_i  = 32'h111;
      chk("ex3.ctrl", 32'(bus_b.alu_ctrl_o), 32'd2);
      chk("ex3.valid_n1", 32'(bus_b.res_valid_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("ex3.valid_n2", 32'(bus_b.res_valid_o), 32'd0);
      bus_b.alu_data_i = 32'h222;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("ex3.valid_n3", 32'(bus_b.res_valid_o), 32'd0);
      chk("ex3.ready_n3", 32'(bus_b.req_ready_o), 32'd0);
      bus_b.alu_data_i = 32'h333;
      bus_b.alu_zero_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("ex3.valid", 32'(bus_b.res_valid_o), 32'd1);
      chk("ex3.res", bus_b.res_data_o, 32'h333);
      chk("ex3.rd", 32'(bus_b.res_rd_o), 32'd4);
      bus_b.alu_data_i = 32'h444;
      bus_b.alu_zero_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("ex3.hold_res", bus_b.res_data_o, 32'h333);
      chk("ex3.hold_zero", 32'(bus_b.res_zero_o), 32'd0);
      bus_b.res_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      bus_b.res_ready_i = 1'b0;
      chk("ex3.count", 32'(bus_b.op_count_o), 32'd1);

      // reset in EXEC aborts the op
      bus_b.req_valid_i = 1'b1;
      bus_b.ALUOp_i     = 2'b01;
      bus_b.rs_data_i   = 32'd5;
      bus_b.rt_data_i   = 32'd5;
      @(posedge clk_i);
      @(negedge clk_i);
      bus_b.req_valid_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_b = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk_reset("rst_exec", bus_b.res_valid_o, bus_b.req_ready_o, bus_b.op_count_o,
                bus_b.alu_data1_o, bus_b.alu_data2_o, bus_b.alu_ctrl_o, bus_b.res_data_o);
      rst_b = 1'b1;
      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_exec.no_result", 32'(bus_b.res_valid_o), 32'd0);

      // reset in DONE drops the pending result
      drive_a(2'b00, 6'b0, 32'd8, 32'd8, 32'd0, 1'b0, 5'd2);
      @(posedge clk_i);
      @(negedge clk_i);
      bus_a.req_valid_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_done.pre_valid", 32'(bus_a.res_valid_o), 32'd1);
      chk("rst_done.pre_res", bus_a.res_data_o, 32'd16);
      rst_a = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk_reset("rst_done", bus_a.res_valid_o, bus_a.req_ready_o, bus_a.op_count_o,
                bus_a.alu_data1_o, bus_a.alu_data2_o, bus_a.alu_ctrl_o, bus_a.res_data_o);
      rst_a = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/capture controller on the driving side of the single-cycle ALU.
- Accepts a decoded EX-stage request (ALUOp, funct, operands, immediate, destination).
- Encodes the 3-bit ALU control word and drives registered operands into the ALU.
- Holds the ALU inputs for a programmable settle time, captures result and zero flag, and returns them over a valid/ready handshake to the writeback/branch logic.

Parameters:
WIDTH, 32, datapath width of operands and result
EXEC_CYCLES, 1, cycles the ALU inputs are held before capture (>=1; multicycle-path budget)
CNT_W, 16, width of retired-operation counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&&ready
ALUOp_i  in  2  00 add, 01 sub/branch, 10 R-type (use funct), 11 or-immediate
funct_i  in  6  R-type function field
rs_data_i  in  WIDTH  operand A
rt_data_i  in  WIDTH  operand B (register)
imm_i  in  WIDTH  sign-extended immediate
ALUSrc_i  in  1  1: operand B = imm_i, 0: rt_data_i
rd_addr_i  in  5  destination register tag
alu_data1_o  out  WIDTH  to ALU data1
alu_data2_o  out  WIDTH  to ALU data2
alu_ctrl_o  out  3  to ALU control
alu_data_i  in  WIDTH  ALU result
alu_zero_i  in  1  ALU zero flag
res_valid_o  out  1  result valid
res_ready_i  in  1  consumer ready
res_data_o  out  WIDTH  captured result
res_zero_o  out  1  captured zero flag
res_branch_o  out  1  1 when op was ALUOp 01 and zero captured = 1
res_rd_o  out  5  destination tag of captured op
res_illegal_o  out  1  unsupported funct under ALUOp 10
op_count_o  out  CNT_W  results handed off since reset, wraps

Behaviour:
- Reset (rst_i=0 at a clock edge): state IDLE; all outputs 0 except req_ready_o=1; settle counter 0; op_count_o=0. Reset in any state aborts the in-flight op with no result emitted.
- Control encoding (latched at accept):
  - ALUOp 00 -> 010 (add)
  - ALUOp 01 -> 110 (sub)
  - ALUOp 11 -> 001 (or)
  - ALUOp 10, funct 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
  - Any other funct -> 010 and illegal flag = 1.
- Operand latch at accept: data1 = rs_data_i; data2 = ALUSrc_i ? imm_i : rt_data_i. Also latched: rd tag, branch-op flag (ALUOp==01).
- alu_data1_o, alu_data2_o and alu_ctrl_o come straight from these registers; no combinational path from req inputs to the ALU ports.
- FSM:
  - IDLE: req_ready_o=1. On valid&&ready: latch, counter <= EXEC_CYCLES-1, go to EXEC.
  - EXEC: req_ready_o=0. If counter==0: capture alu_data_i/alu_zero_i into res regs, res_valid_o<=1, go to DONE. Else decrement counter.
  - DONE: res_valid_o=1; res_* stable until the handshake. req_ready_o = res_ready_i (combinational). On res_ready_i=1: op_count_o++, res_valid_o<=0.
    - If req_valid_i is also 1: accept the new request in the same edge, go to EXEC (back-to-back).
    - Otherwise go to IDLE.
- Latency: accept at edge N; capture at edge N+EXEC_CYCLES; res_valid_o high from N+EXEC_CYCLES. Peak throughput: one op per EXEC_CYCLES+1 cycles.
- ALU outputs are ignored outside the capture edge. ALU inputs hold their last values in IDLE/DONE until the next accept.
- op_count_o wraps from 2^CNT_W-1 to 0.
- req_valid_i in EXEC is not accepted; requester must hold it.

Test Plan:
- R-type add: rs=5, rt=7, ALUOp=10, funct=100000, rd=3, EXEC_CYCLES=1 -> alu_ctrl_o=010 one cycle after accept; res_data_o=12, res_zero_o=0, res_rd_o=3, res_valid_o two edges after accept.
- beq-style sub: rs=rt=0x1234, ALUOp=01 -> alu_ctrl_o=110; res_data_o=0, res_zero_o=1, res_branch_o=1.
- Immediate path: rs=0xF0, imm=0x0F, ALUSrc=1, ALUOp=11 -> alu_data2_o=0x0F, alu_ctrl_o=001, res_data_o=0xFF. Repeat with funct=101010, rs=3, rt=9, ALUOp=10 -> ctrl=111, res=1. Funct=000000 -> ctrl=010, res_illegal_o=1.
- Backpressure/back-to-back: hold res_ready_i=0 for 4 cycles -> res_* stable, req_ready_o=0. Then raise res_ready_i with a new request valid in the same cycle -> new op accepted on that edge, op_count_o increments by 1, no IDLE cycle in between.
- EXEC_CYCLES=3 variant: accept at edge N -> capture at N+3. Changing ALU result at N+1 and N+2 does not affect the result; only the value at edge N+3 is captured.
- Reset mid-EXEC and mid-DONE -> next edge: res_valid_o=0, req_ready_o=1, op_count_o=0, ALU port outputs 0.
